// File: rtl/cpu_axi_arbiter_if.sv
// Single-beat AXI channel bundle between the core-side arbiter (master) and the bus (slave).
// ID, len, burst, cache, prot, lock and wlast are tied off outside this bundle.
interface cpu_axi_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arsize, arvalid, rready,
    output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  araddr, arsize, arvalid, rready,
    input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/cpu_axi_arbiter.sv
// Shares one single-beat AXI master between the inst and data sram-like requesters.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise data always beats inst.
module cpu_axi_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [1:0]        inst_size,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  cpu_axi_arbiter_if.master axi
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB, StDone} state_e;

  state_e            state_q, state_d;
  logic              owner_q;  // 1 = data side
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [31:0]       inst_rdata_q, data_rdata_q;
  logic              grant_data;
  logic              accept;

`ifdef ARB_RR_EN
  logic last_owner_q;  // 1 = data side; reset to inst so data wins the first tie
  assign grant_data = data_req & (~inst_req | ~last_owner_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= 1'b0;
    end else if (accept) begin
      last_owner_q <= grant_data;
    end
  end
`else
  assign grant_data = data_req;
`endif

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (inst_req || data_req) begin
          accept       = 1'b1;
          data_addr_ok = grant_data;
          inst_addr_ok = ~grant_data;
          state_d      = (grant_data && data_wr) ? StAwW : StAr;
        end
      end
      StAr:   if (axi.arready) state_d = StR;
      StR:    if (axi.rvalid) state_d = StDone;
      StAwW: begin
        // Both handshakes may land in the same cycle.
        if ((aw_done_q || axi.awready) && (w_done_q || axi.wready)) state_d = StB;
      end
      StB:    if (axi.bvalid) state_d = StDone;
      StDone: begin
        data_data_ok = owner_q;
        inst_data_ok = ~owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    if (state_q == StAwW && state_d == StAwW) begin
      aw_done_d = aw_done_q | axi.awready;
      w_done_d  = w_done_q | axi.wready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      owner_q <= grant_data;
      wr_q    <= grant_data & data_wr;
      addr_q  <= grant_data ? data_addr : inst_addr;
      size_q  <= grant_data ? data_size : inst_size;
      wdata_q <= data_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else if (state_q == StR && axi.rvalid) begin
      if (owner_q) data_rdata_q <= axi.rdata;
      else         inst_rdata_q <= axi.rdata;
    end
  end

  // Size 3 is reserved and falls through to a full-word strobe.
  always_comb begin
    case (size_q)
      2'd0:    axi.wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    axi.wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: axi.wstrb = 4'b1111;
    endcase
  end

  assign inst_rdata  = inst_rdata_q;
  assign data_rdata  = data_rdata_q;

  assign axi.araddr  = addr_q;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arvalid = (state_q == StAr);
  assign axi.rready  = (state_q == StR);
  assign axi.awaddr  = addr_q;
  assign axi.awsize  = {1'b0, size_q};
  assign axi.awvalid = (state_q == StAwW) & ~aw_done_q;
  assign axi.wdata   = wdata_q;
  assign axi.wvalid  = (state_q == StAwW) & ~w_done_q;
  assign axi.bready  = (state_q == StB);

  logic unused_wr;
  assign unused_wr = wr_q;

endmodule
